// File: rtl/lrs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lrs_pkg
//  Description : Shared constants and state encoding for the MEM-stage
//                load-return selector (load_return_sel).
//  Revision    : 1.0 - initial release
// ============================================================================
package lrs_pkg;

    // Fixed source indices; bridge devices follow from index 2 upwards
    localparam int unsigned c_SRC_CP0 = 0;
    localparam int unsigned c_SRC_DM  = 1;

    // Addresses below this boundary belong to data memory
    localparam logic [31:0] c_DM_LIMIT_DEFAULT = 32'h0000_3000;

    // Two-state controller: idle, or waiting on a slow device
    typedef logic [0:0] lrs_state_t;
    localparam lrs_state_t c_ST_IDLE = 1'b0;
    localparam lrs_state_t c_ST_WAIT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/lrs_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : lrs_addr_decode
//  Description : Combinational source decode for a load. CP0 override first,
//                then the DM window, then one bridge device per address slot
//                of 2**DEV_SHIFT bytes above DM_LIMIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module lrs_addr_decode
    import lrs_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               N_DEV     = 4,
    parameter logic [WIDTH-1:0] DM_LIMIT  = WIDTH'(c_DM_LIMIT_DEFAULT),
    parameter int               DEV_SHIFT = 4,
    parameter int               SEL_W     = $clog2(N_DEV + 2)
) (
    input  logic [WIDTH-1:0] req_addr,
    input  logic             req_cp0,
    output logic [SEL_W-1:0] sel,
    output logic             unmapped
);

    // Highest legal source index, held at full address width so the
    // range check sees every bit of the computed index
    localparam logic [WIDTH-1:0] c_LAST_SRC = WIDTH'(N_DEV + 1);

    logic [WIDTH-1:0] w_offset;
    logic [WIDTH-1:0] w_idx;

    // Priority decode: CP0, then DM, then device slot (unsigned compare)
    always_comb begin
        w_offset = req_addr - DM_LIMIT;
        w_idx    = WIDTH'(2) + (w_offset >> DEV_SHIFT);
        sel      = '0;
        unmapped = 1'b0;
        if (req_cp0) begin
            sel = SEL_W'(c_SRC_CP0);
        end else if (req_addr < DM_LIMIT) begin
            sel = SEL_W'(c_SRC_DM);
        end else if (w_idx > c_LAST_SRC) begin
            unmapped = 1'b1;
        end else begin
            sel = w_idx[SEL_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/load_return_sel.sv
`default_nettype none
// ============================================================================
//  Module      : load_return_sel
//  Description : MEM-stage load-return selector and holding buffer. Picks
//                read data from CP0, DM or a bridge device, stalls the
//                pipeline while a slow device responds, times out silent
//                devices, and presents one registered result per load to W.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_return_sel
    import lrs_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               N_DEV     = 4,
    parameter logic [WIDTH-1:0] DM_LIMIT  = WIDTH'(c_DM_LIMIT_DEFAULT),
    parameter int               DEV_SHIFT = 4,
    parameter int               TIMEOUT   = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [WIDTH-1:0]         req_addr,
    input  logic                     req_cp0,
    input  logic                     flush,
    input  logic [(N_DEV+2)*WIDTH-1:0] src_rdata,
    input  logic [N_DEV+1:0]         src_rvalid,
    output logic                     stall,
    output logic [WIDTH-1:0]         rdata_w,
    output logic                     rvalid_w,
    output logic                     bus_err
);

    localparam int c_N_SRC = N_DEV + 2;
    localparam int c_SEL_W = $clog2(c_N_SRC);
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

    lrs_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_SEL_W-1:0] r_sel_q;

    logic [c_SEL_W-1:0] w_sel;
    logic               w_unmapped;
    logic [WIDTH-1:0]   w_req_data;
    logic               w_req_ok;
    logic [WIDTH-1:0]   w_wait_data;
    logic               w_wait_ok;
    logic               w_timeout;

    lrs_addr_decode #(
        .WIDTH     (WIDTH),
        .N_DEV     (N_DEV),
        .DM_LIMIT  (DM_LIMIT),
        .DEV_SHIFT (DEV_SHIFT),
        .SEL_W     (c_SEL_W)
    ) u_decode (
        .req_addr (req_addr),
        .req_cp0  (req_cp0),
        .sel      (w_sel),
        .unmapped (w_unmapped)
    );

    // Source muxes: one for the live request, one for the latched source in WAIT
    always_comb begin
        w_req_data  = '0;
        w_req_ok    = 1'b0;
        w_wait_data = '0;
        w_wait_ok   = 1'b0;
        for (int i = 0; i < c_N_SRC; i++) begin
            if (w_sel == c_SEL_W'(i)) begin
                w_req_data = src_rdata[i*WIDTH +: WIDTH];
                w_req_ok   = src_rvalid[i];
            end
            if (r_sel_q == c_SEL_W'(i)) begin
                w_wait_data = src_rdata[i*WIDTH +: WIDTH];
                w_wait_ok   = src_rvalid[i];
            end
        end
    end

    assign w_timeout = (r_cnt == c_TIMEOUT);

    // Stall only while a mapped load is still missing its data; flush always releases
    always_comb begin
        stall = 1'b0;
        if (!flush) begin
            if (r_state == c_ST_IDLE) begin
                stall = req_valid && !w_unmapped && !w_req_ok;
            end else begin
                stall = !w_wait_ok && !w_timeout;
            end
        end
    end

    // Controller, timeout counter, latched source and registered W-stage outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_sel_q  <= '0;
            rdata_w  <= '0;
            rvalid_w <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            // Result strobes are single-cycle pulses; rdata_w holds otherwise
            rvalid_w <= 1'b0;
            bus_err  <= 1'b0;
            if (flush) begin
                r_state <= c_ST_IDLE;
                r_cnt   <= '0;
            end else if (r_state == c_ST_IDLE) begin
                if (req_valid) begin
                    if (w_unmapped) begin
                        rdata_w  <= '0;
                        rvalid_w <= 1'b1;
                        bus_err  <= 1'b1;
                    end else if (w_req_ok) begin
                        rdata_w  <= w_req_data;
                        rvalid_w <= 1'b1;
                    end else begin
                        r_state <= c_ST_WAIT;
                        r_sel_q <= w_sel;
                        r_cnt   <= c_CNT_W'(1);
                    end
                end
            end else begin
                if (w_wait_ok) begin
                    rdata_w  <= w_wait_data;
                    rvalid_w <= 1'b1;
                    r_state  <= c_ST_IDLE;
                    r_cnt    <= '0;
                end else if (w_timeout) begin
                    rdata_w  <= '0;
                    rvalid_w <= 1'b1;
                    bus_err  <= 1'b1;
                    r_state  <= c_ST_IDLE;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
